// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light monitor: phases, fault causes, FSM states
// and the width constants used by the monitor datapath.
package traffic_pkg;

    localparam int unsigned TimeW  = 6;
    localparam int unsigned CycleW = 8;
    localparam int unsigned LampW  = 6;

    localparam logic [TimeW-1:0] DurMax = 6'd63;

    typedef enum logic [2:0] {
        PhNone = 3'd0,
        PhHgFr = 3'd1,
        PhHyFr = 3'd2,
        PhHrFg = 3'd3,
        PhHrFy = 3'd4
    } phaseT;

    typedef enum logic [2:0] {
        FcNone    = 3'd0,
        FcIllegal = 3'd1,
        FcOrder   = 3'd2,
        FcShort   = 3'd3,
        FcStuck   = 3'd4
    } faultT;

    typedef enum logic [1:0] {
        StSync  = 2'd0,
        StTrack = 2'd1,
        StFault = 2'd2
    } stateT;

    // Successor of a legal phase in the only permitted rotation.
    function automatic phaseT nextPhase(input phaseT p);
        phaseT n;
        n = PhNone;
        case (p)
            PhHgFr:  n = PhHyFr;
            PhHyFr:  n = PhHrFg;
            PhHrFg:  n = PhHrFy;
            PhHrFy:  n = PhHgFr;
            default: n = PhNone;
        endcase
        return n;
    endfunction

    function automatic logic isGreen(input phaseT p);
        return (p == PhHgFr) || (p == PhHrFg);
    endfunction

endpackage

// File: rtl/lamp_decode.sv
// Combinational decode of the registered lamp vector {HR,HY,HG,FR,FY,FG}
// into a phase code plus a legal flag.
module lamp_decode
    import traffic_pkg::*;
(
    input  logic [LampW-1:0] lampVec_i,
    output phaseT            phase_o,
    output logic             legal_o
);

    always_comb begin
        phase_o = PhNone;
        legal_o = 1'b0;
        case (lampVec_i)
            6'b001100: begin phase_o = PhHgFr; legal_o = 1'b1; end
            6'b010100: begin phase_o = PhHyFr; legal_o = 1'b1; end
            6'b100001: begin phase_o = PhHrFg; legal_o = 1'b1; end
            6'b100010: begin phase_o = PhHrFy; legal_o = 1'b1; end
            default:   begin phase_o = PhNone; legal_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Observes a traffic-light controller's lamp drives, tracks phase order and duration,
// and latches the first fault (illegal lamps, bad order, short phase, stuck phase).
module traffic_light_monitor
    import traffic_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              HR,
    input  logic              HY,
    input  logic              HG,
    input  logic              FR,
    input  logic              FY,
    input  logic              FG,
    input  logic [TimeW-1:0]  ShortTime_i,
    input  logic [TimeW-1:0]  LongTime_i,
    input  logic              clr_i,
    output logic [2:0]        phase_o,
    output logic              phase_valid_o,
    output logic [TimeW-1:0]  dur_o,
    output logic              dur_valid_o,
    output logic [CycleW-1:0] cycle_cnt_o,
    output logic              fault_o,
    output logic [2:0]        fault_code_o
);

    logic [LampW-1:0]  lampQ;
    phaseT             decPhase;
    logic              decLegal;

    stateT             stateQ, stateD;
    phaseT             phaseQ, phaseD;
    logic [TimeW-1:0]  cntQ, cntD;
    logic [TimeW-1:0]  durQ, durD;
    logic              durValidQ, durValidD;
    logic              partialQ, partialD;
    logic [CycleW-1:0] cycleQ, cycleD;
    faultT             codeQ, codeD;

    logic [TimeW-1:0]  limit;
    logic [TimeW-1:0]  cntInc;
    logic              shortViol;

    lamp_decode u_lamp_decode (
        .lampVec_i (lampQ),
        .phase_o   (decPhase),
        .legal_o   (decLegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lampQ <= '0;
        end else begin
            lampQ <= {HR, HY, HG, FR, FY, FG};
        end
    end

    // A zero limit disables the short check for that phase class.
    always_comb begin
        limit     = isGreen(phaseQ) ? LongTime_i : ShortTime_i;
        shortViol = !partialQ && (limit != '0) && (cntQ < limit);
        cntInc    = (cntQ == DurMax) ? DurMax : cntQ + 1'b1;
    end

    always_comb begin
        stateD    = stateQ;
        phaseD    = phaseQ;
        cntD      = cntQ;
        durD      = durQ;
        durValidD = 1'b0;
        partialD  = partialQ;
        cycleD    = cycleQ;
        codeD     = codeQ;

        if (clr_i) begin
            stateD   = StSync;
            phaseD   = PhNone;
            cntD     = '0;
            partialD = 1'b1;
            codeD    = FcNone;
        end else begin
            unique case (stateQ)
                StSync: begin
                    if (decLegal) begin
                        stateD   = StTrack;
                        phaseD   = decPhase;
                        cntD     = 6'd1;
                        partialD = 1'b1;
                    end
                end
                StTrack: begin
                    if (!decLegal) begin
                        stateD = StFault;
                        codeD  = FcIllegal;
                    end else if (decPhase == phaseQ) begin
                        cntD = cntInc;
                        if (cntInc == DurMax) begin
                            stateD = StFault;
                            codeD  = FcStuck;
                        end
                    end else if (decPhase != nextPhase(phaseQ)) begin
                        stateD = StFault;
                        codeD  = FcOrder;
                    end else if (shortViol) begin
                        stateD = StFault;
                        codeD  = FcShort;
                    end else begin
                        phaseD   = decPhase;
                        cntD     = 6'd1;
                        partialD = 1'b0;
                        if (!partialQ) begin
                            durD      = cntQ;
                            durValidD = 1'b1;
                        end
                        if (phaseQ == PhHrFy) begin
                            cycleD = cycleQ + 1'b1;
                        end
                    end
                end
                StFault: begin
                    stateD = StFault;
                end
                default: begin
                    stateD = StSync;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StSync;
            phaseQ    <= PhNone;
            cntQ      <= '0;
            durQ      <= '0;
            durValidQ <= 1'b0;
            partialQ  <= 1'b1;
            cycleQ    <= '0;
            codeQ     <= FcNone;
        end else begin
            stateQ    <= stateD;
            phaseQ    <= phaseD;
            cntQ      <= cntD;
            durQ      <= durD;
            durValidQ <= durValidD;
            partialQ  <= partialD;
            cycleQ    <= cycleD;
            codeQ     <= codeD;
        end
    end

    assign phase_o       = phaseQ;
    assign phase_valid_o = (stateQ == StTrack);
    assign dur_o         = durQ;
    assign dur_valid_o   = durValidQ;
    assign cycle_cnt_o   = cycleQ;
    assign fault_o       = (stateQ == StFault);
    assign fault_code_o  = codeQ;

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 HR,HY,HG,FR,FY,FG  input  1 each  highway/farm lamp drives from the controller under observation.
REQ-004 ShortTime_i  input  6  minimum legal yellow-phase duration, in cycles.
REQ-005 LongTime_i  input  6  minimum legal green-phase duration, in cycles.
REQ-006 clr_i  input  1  synchronous fault clear; returns monitor to SYNC.
REQ-007 phase_o  output  3  decoded current phase (package encoding).
REQ-008 phase_valid_o  output  1  high while in TRACK.
REQ-009 dur_o  output  6  duration of the most recently completed phase.
REQ-010 dur_valid_o  output  1  one-cycle pulse when dur_o updates.
REQ-011 cycle_cnt_o  output  8  count of completed full light cycles.
REQ-012 fault_o  output  1  sticky fault flag.
REQ-013 fault_code_o  output  3  cause of the first fault.

Function
REQ-014 Lamp vector {HR,HY,HG,FR,FY,FG} SHALL be registered once; the registered vector at edge N drives the state and output updates at edge N+1.
REQ-015 Legal decodes SHALL be: 001100=HG_FR, 010100=HY_FR, 100001=HR_FG, 100010=HR_FY; every other vector is ILLEGAL.
REQ-016 Legal phase order SHALL be HG_FR->HY_FR->HR_FG->HR_FY->HG_FR; any other change between legal phases is an illegal transition.
REQ-017 FSM states SHALL be SYNC, TRACK, FAULT.
REQ-018 SYNC: ILLEGAL vectors ignored; first legal vector -> TRACK, dur counter=1, first phase marked partial.
REQ-019 TRACK: same phase -> dur counter +1, saturating at 63.
REQ-020 TRACK, legal phase change: dur_o<=counter, dur_valid_o=1 for one cycle (suppressed for the partial phase); counter<=1.
REQ-021 Short check on completed non-partial phase: green phases (HG_FR, HR_FG) require dur>=LongTime_i; yellow phases (HY_FR, HR_FY) require dur>=ShortTime_i; violation -> FAULT, code 3.
REQ-022 ILLEGAL vector in TRACK -> FAULT, code 1; illegal transition -> FAULT, code 2; counter reaching 63 -> FAULT, code 4.
REQ-023 Simultaneous causes: priority is code 1 > 2 > 3 > 4.
REQ-024 HR_FY->HG_FR transition SHALL increment cycle_cnt_o, wrapping 255->0.
REQ-025 FAULT: fault_o=1, fault_code_o held, phase_valid_o=0, dur_o and cycle_cnt_o frozen; lamp inputs ignored.
REQ-026 clr_i in any state -> SYNC next edge, fault_o=0, fault_code_o=0, cycle_cnt_o kept; clr_i and fault in the same cycle: clr_i wins.
REQ-027 ShortTime_i/LongTime_i SHALL be sampled at the compare edge; a limit of 0 means no short check for that phase class.

Reset
REQ-028 rst SHALL asynchronously force SYNC, lamp register=000000, counter=0, phase_o=0, phase_valid_o=0, dur_o=0, dur_valid_o=0, cycle_cnt_o=0, fault_o=0, fault_code_o=0.
REQ-029 rst asserted mid-phase SHALL discard the partial duration; after release the first phase is treated as partial.

Structure
REQ-030 Package traffic_pkg SHALL hold the phase encodings, fault codes (NONE=0, ILLEGAL=1, ORDER=2, SHORT=3, STUCK=4), the FSM state encodings, and width constants (6-bit time, 8-bit cycle count).
REQ-031 Sub-module lamp_decode SHALL be combinational: 6-bit vector -> phase, legal flag.

Verification
REQ-032 ShortTime=3, LongTime=10; drive HG_FR 12, HY_FR 4, HR_FG 12, HR_FY 4, HG_FR -> no fault, cycle_cnt_o=1, dur_o pulses 4, 12, 4 (first phase partial, so no pulse for it).
REQ-033 In TRACK, drive 001001 (HG+FG) for 1 cycle -> fault_o=1, fault_code_o=1 two edges later; outputs frozen.
REQ-034 HG_FR 12 then directly HR_FG -> fault_code_o=2.
REQ-035 Full phase HY_FR held 2 cycles with ShortTime=3 -> fault_code_o=3; then clr_i -> fault_o=0, state SYNC.
REQ-036 Hold HG_FR 70 cycles -> fault_code_o=4 when the counter hits 63.
REQ-037 Assert rst mid-HR_FG, release, continue the sequence -> no dur_valid_o for the first phase, no false SHORT fault.
